hamming_encoder_pipe: RTL

Registered SECDED Hamming encoder that sits directly upstream of hamming_decoder.
- Accepts raw data words over a valid/ready handshake.
- Computes even-parity Hamming check bits plus one overall parity bit.
- Presents the codeword through a 2-entry skid-buffered output stage, so back-pressure never drops or duplicates words.
- Output bit layout is exactly the layout hamming_decoder consumes.

---
 rtl/hamming_pkg.sv | 34 +++
 rtl/hamming_encoder_pipe_if.sv | 22 ++
 rtl/hamming_encoder_core.sv | 43 ++++
 rtl/hamming_encoder_pipe.sv | 119 +++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared SECDED Hamming helpers: width derivations, output-stage state type and
// the data-bit to codeword-index mapping.
package hamming_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } hstate_e;

    function automatic int parity_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

    function automatic int enc_width(input int dw);
        return dw + parity_width(dw);
    endfunction

    // Data bit i lands on the i-th non-power-of-2 Hamming position (index = position-1).
    function automatic int data_idx(input int i);
        int n;
        int res;
        n   = 0;
        res = 0;
        for (int pos = 3; pos < 256; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (n == i) res = pos - 1;
                n++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hamming_encoder_pipe_if.sv
// Valid/ready stream bundle around the encoder: raw words in, codewords out.
interface hamming_encoder_pipe_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ENC_WIDTH  = hamming_pkg::enc_width(DATA_WIDTH)
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [ENC_WIDTH:0]    o_enc_data;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_enc_data
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_enc_data
    );
endinterface

// File: rtl/hamming_encoder_core.sv
// Combinational SECDED encoder: data word -> {overall parity, Hamming codeword}.
module hamming_encoder_core
    import hamming_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    localparam int PARITY_WIDTH = parity_width(DATA_WIDTH),
    localparam int ENC_WIDTH    = enc_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [ENC_WIDTH:0]    cw_o
);

    function automatic logic [ENC_WIDTH-1:0] cover_mask(input int k);
        logic [ENC_WIDTH-1:0] m;
        m = '0;
        for (int n = 0; n < ENC_WIDTH; n++) m[n] = (((n + 1) >> k) & 1) != 0;
        return m;
    endfunction

    logic [ENC_WIDTH-1:0]    raw;
    logic [ENC_WIDTH-1:0]    hc;
    logic [PARITY_WIDTH-1:0] chk;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_dat
        localparam int IDX = data_idx(i);
        assign raw[IDX] = data_i[i];
    end

    // Check slots are zero in raw, so each mask can safely include its own slot.
    for (genvar k = 0; k < PARITY_WIDTH; k++) begin : g_chk
        localparam logic [ENC_WIDTH-1:0] MASK = cover_mask(k);
        assign raw[(1 << k) - 1] = 1'b0;
        assign chk[k]            = ^(raw & MASK);
    end

    always_comb begin
        hc = raw;
        for (int k = 0; k < PARITY_WIDTH; k++) hc[(1 << k) - 1] = chk[k];
    end

    assign cw_o = {^hc, hc};

endmodule

// File: rtl/hamming_encoder_pipe.sv
// Registered SECDED encoder with a 2-entry skid output stage.
// Optional error injection on the stored codeword: define HAMMING_ERR_INJECT_EN.
module hamming_encoder_pipe
    import hamming_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int CNT_WIDTH  = 16,
    localparam int ENC_WIDTH  = enc_width(DATA_WIDTH),
    localparam int POS_WIDTH  = $clog2(ENC_WIDTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    hamming_encoder_pipe_if.slave bus,
    output logic [CNT_WIDTH-1:0] o_word_cnt,
    input  logic [1:0]           i_inj_mode,
    input  logic [POS_WIDTH-1:0] i_inj_pos
);

    hstate_e              state_q;
    logic                 valid_q;
    logic                 ready_q;
    logic [ENC_WIDTH:0]   out_q;
    logic [ENC_WIDTH:0]   skid_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic [ENC_WIDTH:0]   cw;
    logic [ENC_WIDTH:0]   flip;
    logic [ENC_WIDTH:0]   enc_d;
    logic                 push;
    logic                 pop;

    hamming_encoder_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .data_i (bus.i_data),
        .cw_o   (cw)
    );

`ifdef HAMMING_ERR_INJECT_EN
    localparam logic [POS_WIDTH-1:0] ENC_POS = POS_WIDTH'(ENC_WIDTH);
    logic [POS_WIDTH-1:0] pos_nxt;

    always_comb begin
        flip    = '0;
        pos_nxt = (i_inj_pos == ENC_POS) ? '0 : i_inj_pos + 1'b1;
        if (i_inj_pos <= ENC_POS) begin
            case (i_inj_mode)
                2'b01: flip[i_inj_pos] = 1'b1;
                2'b10: begin
                    flip[i_inj_pos] = 1'b1;
                    flip[pos_nxt]   = 1'b1;
                end
                2'b11: flip[ENC_WIDTH] = 1'b1;
                default: ;
            endcase
        end
    end
`else
    logic unused_inj;
    assign unused_inj = ^{i_inj_mode, i_inj_pos};
    assign flip       = '0;
`endif

    assign enc_d = cw ^ flip;
    assign push  = bus.i_valid & ready_q;
    assign pop   = valid_q & bus.i_ready;

    // Handshake flags are registered alongside the state so o_ready never
    // depends combinationally on the downstream i_ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (push) cnt_q <= cnt_q + 1'b1;
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        out_q   <= enc_d;
                        valid_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_q <= enc_d;
                    end else if (pop) begin
                        valid_q <= 1'b0;
                        state_q <= EMPTY;
                    end else if (push) begin
                        skid_q  <= enc_d;
                        ready_q <= 1'b0;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_q   <= skid_q;
                        ready_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_ready    = ready_q;
    assign bus.o_enc_data = out_q;
    assign o_word_cnt     = cnt_q;

endmodule
